// File: rtl/eth_fifo_pkg.sv
// Shared types and constants for the Ethernet async FIFO read-side logic.
package eth_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      DISCARD = 2'd2
   } rd_state_t;

   localparam int unsigned FIFO_RD_LATENCY = 1;

   // One slot per cycle of read latency plus the entry being presented.
   localparam int unsigned PREFETCH_DEPTH = FIFO_RD_LATENCY + 1;

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Two-entry register buffer that absorbs FIFO read latency; head entry drives dout.
module fifo_rd_prefetch_buf
   import eth_fifo_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             pop_ok, push_ok;

   always_comb begin
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'(PREFETCH_DEPTH)) || pop_ok);
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = din;
            end else begin
               tail_d = din;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push/pop: the new entry lands behind whatever remains.
            if (count_q == 2'd1) begin
               head_d = din;
            end else begin
               head_d = tail_q;
               tail_d = din;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign dout  = head_q;
   assign count = count_q;

endmodule

// File: rtl/fifo_axis_rd_adapter.sv
// Pops {tlast, tdata} entries from the async FIFO read side and streams them as an
// AXI-Stream master, truncating frames longer than MAX_FRAME_LEN and discarding their tail.
module fifo_axis_rd_adapter
   import eth_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH    = 8,
   parameter  int MAX_FRAME_LEN = 1518,
   localparam int LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH:0]   fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic                  frame_done,
   output logic [LEN_W-1:0]      frame_len,
   output logic                  frame_err
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

   rd_state_t             state_q, state_d;
   logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [LEN_W-1:0]      frame_len_q, frame_len_d;
   logic                  frame_done_q, frame_done_d;
   logic                  frame_err_q, frame_err_d;
   logic                  inflight_q;

   logic [DATA_WIDTH:0]   head;
   logic [1:0]            buf_count;
   logic                  head_last, tvalid, force_last, beat, pop;
   logic [2:0]            occupancy;
   logic [LEN_W-1:0]      cnt_inc;

   fifo_rd_prefetch_buf #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_prefetch (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (inflight_q),
      .pop     (pop),
      .din     (fifo_rd_data),
      .dout    (head),
      .count   (buf_count)
   );

   always_comb begin
      head_last  = head[DATA_WIDTH];
      tvalid     = (buf_count != 2'd0) && (state_q != DISCARD);
      force_last = tvalid && (state_q == ACTIVE) && !head_last &&
                   ((beat_cnt_q + LEN_W'(1)) == MAX_LEN);
      beat       = tvalid && m_axis_tready;
      pop        = beat || ((state_q == DISCARD) && (buf_count != 2'd0));
      occupancy  = {1'b0, buf_count} + {2'b00, inflight_q};
      cnt_inc    = (beat_cnt_q == MAX_LEN) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);
      // A slot freed by this cycle's pop counts as room so streaming keeps 1 beat/clk;
      // reset_n gating stops the FIFO being popped while the block is held in reset.
      fifo_rd_en = reset_n && !fifo_empty &&
                   (occupancy < (3'(PREFETCH_DEPTH) + {2'b00, pop}));
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      frame_len_d  = frame_len_q;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (beat) begin
               if (head_last) begin
                  frame_len_d  = LEN_W'(1);
                  frame_done_d = 1'b1;
                  beat_cnt_d   = '0;
               end else begin
                  beat_cnt_d = LEN_W'(1);
                  state_d    = ACTIVE;
               end
            end
         end
         ACTIVE: begin
            if (beat) begin
               if (head_last) begin
                  frame_len_d  = cnt_inc;
                  frame_done_d = 1'b1;
                  beat_cnt_d   = '0;
                  state_d      = IDLE;
               end else if (force_last) begin
                  frame_len_d  = MAX_LEN;
                  frame_done_d = 1'b1;
                  frame_err_d  = 1'b1;
                  beat_cnt_d   = '0;
                  state_d      = DISCARD;
               end else begin
                  beat_cnt_d = cnt_inc;
               end
            end
         end
         DISCARD: begin
            if (pop && head_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         frame_len_q  <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         frame_len_q  <= frame_len_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         inflight_q   <= fifo_rd_en;
      end
   end

   assign m_axis_tvalid = tvalid;
   assign m_axis_tdata  = head[DATA_WIDTH-1:0];
   assign m_axis_tlast  = tvalid && (head_last || force_last);
   assign frame_done    = frame_done_q;
   assign frame_len     = frame_len_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_fifo_axis_rd_adapter.sv
// Directed bench for fifo_axis_rd_adapter with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_axis_rd_adapter;

   localparam int DW     = 8;
   localparam int MAXLEN = 1518;
   localparam int LW     = $clog2(MAXLEN + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW:0]   fifo_rd_data;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready;
   logic          frame_done;
   logic [LW-1:0] frame_len;
   logic          frame_err;

   always #5 clk = ~clk;

   fifo_axis_rd_adapter #(
      .DATA_WIDTH    (DW),
      .MAX_FRAME_LEN (MAXLEN)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .frame_done    (frame_done),
      .frame_len     (frame_len),
      .frame_err     (frame_err)
   );

   int          checks = 0;
   int          errors = 0;
   logic [DW:0] fifoQ[$];
   logic [DW:0] expQ[$];
   logic [DW:0] obsQ[$];
   int          lenHist[$];
   logic [DW:0] rdPipe;
   bit          rdPending = 0;
   bit          readyMode = 0;
   bit          prevStall = 0;
   logic [DW:0] prevBeat;
   bit          prevEmpty = 1;
   int          doneCnt, errCnt, stabErr, popCount;
   int          cycleCnt = 0;
   int          firstBeatCyc, lastBeatCyc, emptyFallCyc;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock of the FIFO model and stream sink, driven on the falling edge.
   task automatic applyStimulus();
      @(negedge clk);
      cycleCnt++;
      if (frame_done) begin
         doneCnt++;
         lenHist.push_back(int'(frame_len));
      end
      if (frame_err) errCnt++;
      if (rdPending) begin
         fifo_rd_data = rdPipe;
         rdPending    = 0;
      end
      m_axis_tready = readyMode ? ($urandom_range(0, 1) == 1) : 1'b1;
      fifo_empty    = (fifoQ.size() == 0);
      if (prevEmpty && !fifo_empty) emptyFallCyc = cycleCnt;
      prevEmpty = fifo_empty;
      #1;
      if (prevStall && !(m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} == prevBeat)))
         stabErr++;
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevBeat  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) begin
         obsQ.push_back({m_axis_tlast, m_axis_tdata});
         if (firstBeatCyc < 0) firstBeatCyc = cycleCnt;
         lastBeatCyc = cycleCnt;
      end
      if (fifo_rd_en) begin
         rdPipe    = fifoQ.pop_front();
         rdPending = 1;
         popCount++;
      end
   endtask

   task automatic clearScoreboard();
      obsQ.delete();
      expQ.delete();
      lenHist.delete();
      doneCnt      = 0;
      errCnt       = 0;
      stabErr      = 0;
      popCount     = 0;
      firstBeatCyc = -1;
      lastBeatCyc  = -1;
   endtask

   // Beats startIdx..startIdx+n-1 of a frame of 'total' beats; expected stream is truncated at MAXLEN.
   task automatic pushSegment(input int startIdx, input int n, input int total, input logic [7:0] seed);
      for (int i = startIdx; i < startIdx + n; i++) begin
         logic [7:0] d;
         d = seed + 8'(i);
         fifoQ.push_back({(i == total - 1), d});
         if (i < MAXLEN) expQ.push_back({((i == total - 1) || (i == MAXLEN - 1)), d});
      end
   endtask

   task automatic drainStream(input string tag);
      int quiet = 0;
      int cyc   = 0;
      while (quiet < 5 && cyc < 10000) begin
         applyStimulus();
         cyc++;
         if (fifoQ.size() == 0 && !rdPending && !m_axis_tvalid && !fifo_rd_en) quiet++;
         else quiet = 0;
      end
      checkOutput({tag, "_drain_timeout"}, 32'(quiet >= 5), 1);
   endtask

   task automatic runUntilBeats(input string tag, input int nBeats);
      int cyc = 0;
      while (obsQ.size() < nBeats && cyc < 100) begin
         applyStimulus();
         cyc++;
      end
      checkOutput({tag, "_beat_timeout"}, 32'(obsQ.size() >= nBeats), 1);
   endtask

   task automatic checkFrames(input string tag);
      int n;
      checkOutput({tag, "_nbeats"}, obsQ.size(), expQ.size());
      n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("%s_beat%0d", tag, i), 32'(obsQ[i]), 32'(expQ[i]));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
      checkOutput({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
      checkOutput({tag, "_tlast"}, 32'(m_axis_tlast), 0);
      checkOutput({tag, "_tdata"}, 32'(m_axis_tdata), 0);
      checkOutput({tag, "_done"}, 32'(frame_done), 0);
      checkOutput({tag, "_len"}, 32'(frame_len), 0);
      checkOutput({tag, "_err"}, 32'(frame_err), 0);
   endtask

   initial begin
      logic [DW:0] expFirst;
      int          remaining;
      int          gapValid;

      reset_n       = 1'b0;
      fifo_rd_data  = '0;
      fifo_empty    = 1'b1;
      m_axis_tready = 1'b1;
      clearScoreboard();

      $display("[TB] test 1: reset");
      for (int i = 0; i < 10; i++) fifoQ.push_back({(i == 9), 8'hA0 + 8'(i)});
      repeat (2) applyStimulus();
      checkResetOutputs("t1_por");
      @(posedge clk); #1 reset_n = 1'b1;
      runUntilBeats("t1", 3);
      @(posedge clk); #1 reset_n = 1'b0;
      #1 checkResetOutputs("t1_mid");
      prevStall = 0;
      repeat (2) applyStimulus();
      @(posedge clk); #1 reset_n = 1'b1;
      expFirst  = fifoQ[0];
      remaining = fifoQ.size();
      clearScoreboard();
      drainStream("t1");
      checkOutput("t1_nbeats", obsQ.size(), remaining);
      if (obsQ.size() > 0) checkOutput("t1_first", 32'(obsQ[0]), 32'(expFirst));
      checkOutput("t1_done", doneCnt, 1);
      checkOutput("t1_len", 32'(frame_len), remaining);

      $display("[TB] test 2: streaming");
      clearScoreboard();
      pushSegment(0, 64, 64, 8'h00);
      drainStream("t2");
      checkFrames("t2");
      checkOutput("t2_latency", firstBeatCyc - emptyFallCyc, 2);
      checkOutput("t2_back2back", lastBeatCyc - firstBeatCyc, 63);
      checkOutput("t2_done", doneCnt, 1);
      checkOutput("t2_len", 32'(frame_len), 64);
      checkOutput("t2_err", errCnt, 0);

      $display("[TB] test 3: back-pressure");
      clearScoreboard();
      readyMode = 1;
      pushSegment(0, 200, 200, 8'h37);
      drainStream("t3");
      readyMode = 0;
      checkFrames("t3");
      checkOutput("t3_stable", stabErr, 0);
      checkOutput("t3_done", doneCnt, 1);
      checkOutput("t3_len", 32'(frame_len), 200);

      $display("[TB] test 4: oversize");
      clearScoreboard();
      pushSegment(0, 1600, 1600, 8'h10);
      pushSegment(0, 10, 10, 8'h55);
      drainStream("t4");
      checkFrames("t4");
      checkOutput("t4_err", errCnt, 1);
      checkOutput("t4_done", doneCnt, 2);
      if (lenHist.size() == 2) begin
         checkOutput("t4_len_trunc", lenHist[0], 1518);
         checkOutput("t4_len_next", lenHist[1], 10);
      end else begin
         checkOutput("t4_len_hist", lenHist.size(), 2);
      end
      checkOutput("t4_dropped", popCount - obsQ.size(), 82);

      $display("[TB] test 5: underflow");
      clearScoreboard();
      pushSegment(0, 5, 12, 8'h80);
      runUntilBeats("t5", 5);
      gapValid = 0;
      repeat (20) begin
         applyStimulus();
         if (m_axis_tvalid) gapValid++;
      end
      checkOutput("t5_gap_tvalid", gapValid, 0);
      pushSegment(5, 7, 12, 8'h80);
      drainStream("t5");
      checkFrames("t5");
      checkOutput("t5_done", doneCnt, 1);
      checkOutput("t5_len", 32'(frame_len), 12);
      checkOutput("t5_err", errCnt, 0);

      $display("[TB] test 6: edge lengths");
      clearScoreboard();
      pushSegment(0, 1, 1, 8'hC0);
      pushSegment(0, 1518, 1518, 8'h20);
      drainStream("t6");
      checkFrames("t6");
      checkOutput("t6_err", errCnt, 0);
      checkOutput("t6_done", doneCnt, 2);
      if (lenHist.size() == 2) begin
         checkOutput("t6_len_one", lenHist[0], 1);
         checkOutput("t6_len_max", lenHist[1], 1518);
      end else begin
         checkOutput("t6_len_hist", lenHist.size(), 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
